ysyx_23060201_mc_ctrl: RTL and testbench
========================================

Name: ysyx_23060201_mc_ctrl

Overview:
- Multi-cycle successor to the single-cycle core top-level sequencing.
- Owns PC, instruction register and a phase FSM (fetch → execute → memory → writeback).
- Talks to variable-latency instruction and data memories over valid/ready request plus valid response handshakes.
- Hands the latched instruction to the combinational IDU/EXU; gates GPR writes and commit to a single writeback cycle; counts retired instructions.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- XLEN, 32, data and GPR width.
- RESET_PC, 32'h8000_0000, PC value after reset.
- CNT_WIDTH, 64, instret counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  fetch request accepted.
- ifu_req_addr  out  ADDR_WIDTH  fetch address (= pc).
- ifu_rsp_valid  in  1  fetch data valid.
- ifu_rsp_data  in  32  fetched instruction.
- inst  out  32  latched instruction register to IDU/EXU.
- pc  out  ADDR_WIDTH  current PC.
- exu_valid  out  1  EXU outputs sampled this cycle.
- exu_is_load / exu_is_store  in  1 each  memory op class.
- exu_halt  in  1  ebreak decoded.
- exu_jump_en  in  1  redirect.
- exu_dnpc  in  ADDR_WIDTH  redirect target.
- exu_gpr_wen  in  1  writeback enable.
- exu_gpr_waddr  in  5  destination register.
- exu_gpr_wdata  in  XLEN  ALU result.
- exu_mem_addr  in  ADDR_WIDTH  load/store address.
- exu_mem_wdata  in  XLEN  store data.
- exu_mem_wmask  in  8  store byte mask.
- dmem_req_valid  out  1  data request valid.
- dmem_req_ready  in  1  data request accepted.
- dmem_req_wen  out  1  1 = store, 0 = load.
- dmem_req_addr  out  ADDR_WIDTH  data request address.
- dmem_req_wdata  out  XLEN  store data.
- dmem_req_wmask  out  8  store byte mask.
- dmem_rsp_valid  in  1  data response valid.
- dmem_rsp_rdata  in  XLEN  load data.
- gpr_wen  out  1  GPR write strobe.
- gpr_waddr  out  5  GPR write address.
- gpr_wdata  out  XLEN  GPR write data.
- commit_valid  out  1  one-cycle retire pulse.
- commit_pc  out  ADDR_WIDTH  PC of the retired instruction.
- halted  out  1  core stopped.
- instret  out  CNT_WIDTH  retired instruction count.

Behaviour:
- Reset (rst=0, async)
  - state=FETCH, pc=RESET_PC, inst=32'h0000_0013 (nop), instret=0.
  - All valid/strobe outputs 0, halted=0.
  - Reset mid-transaction abandons the transaction; memories are reset together with this block.
- States: FETCH, FWAIT, EXEC, MEM, MWAIT, WB, HALT.
- FETCH
  - ifu_req_valid=1, ifu_req_addr=pc.
  - On ifu_req_valid&ifu_req_ready → FWAIT.
- FWAIT
  - On ifu_rsp_valid: inst<=ifu_rsp_data → EXEC.
  - The response may arrive the cycle after acceptance at the earliest.
- EXEC (exactly 1 cycle)
  - exu_valid=1.
  - Latch jump_en, dnpc, gpr_wen, waddr, wdata, halt, is_load, is_store, mem addr/wdata/wmask.
  - Next state: MEM if is_load|is_store, else WB.
  - is_load&is_store together is illegal; it is treated as store.
- MEM
  - dmem_req_valid=1 with latched fields; dmem_req_wen=is_store; wmask forced 0 for loads.
  - Fields held stable until dmem_req_ready → MWAIT.
- MWAIT
  - On dmem_rsp_valid: for loads, latched wdata<=dmem_rsp_rdata → WB.
  - Stores also wait for dmem_rsp_valid (write acknowledge).
- WB (exactly 1 cycle)
  - gpr_wen = latched wen & (waddr≠0).
  - commit_valid=1, commit_pc=pc.
  - pc <= jump_en ? dnpc : pc+4 (modulo 2^ADDR_WIDTH).
  - instret <= instret+1 (wraps at 2^CNT_WIDTH).
  - Next state: HALT if latched halt, else FETCH.
- HALT
  - halted=1, all requests 0, state frozen until reset.
- Response handling
  - ifu_rsp_valid/dmem_rsp_valid outside FWAIT/MWAIT are ignored.
  - Responses are not accepted in the same cycle as their request.
- Outputs
  - All outputs are registered or decoded from state only; no combinational path from memory inputs to request outputs.
- Latency
  - With ready=1 and 1-cycle responses: ALU instr = 4 cycles (FETCH, FWAIT, EXEC, WB); load/store = 6 cycles.

Test Plan:
- Reset release, ifu ready=1, rsp 1 cycle later with addi x1,x0,5 (0x00500093) → ifu_req_addr=0x8000_0000; WB cycle gpr_wen=1, waddr=1, wdata=5; commit_pc=0x8000_0000; next fetch at 0x8000_0004; instret=1.
- Hold ifu_req_ready=0 for 7 cycles → ifu_req_valid and addr stay stable; no state advance; commit 4 cycles after ready rises when rsp follows immediately.
- Load, exu_mem_addr=0x8000_0100, dmem rsp after 3 cycles with 0xDEAD_BEEF → dmem_req_wen=0, wmask=0; gpr_wdata=0xDEAD_BEEF at WB.
- Store, wmask=0x0F, ready delayed 2 cycles → request fields stable throughout; gpr_wen=0; pc+4.
- Jump with dnpc=0x8000_0040 and waddr=0, wen=1 → gpr_wen=0 (x0 suppressed); next ifu_req_addr=0x8000_0040.
- exu_halt=1 → one commit_valid pulse, then halted=1 with no further requests; assert rst=0 mid-MWAIT on a later run → immediate return to FETCH at RESET_PC, instret=0.

Source files
------------

// File: rtl/ysyx_23060201_mc_ctrl_if.sv
// Memory-side bus bundle for the multi-cycle core controller: an instruction
// fetch channel and a data channel, each a valid/ready request followed by a
// valid-only response. The controller is the master; memories are slaves.
interface ysyx_23060201_mc_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
);
    // Instruction fetch channel
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_WIDTH-1:0] ifu_req_addr;
    logic                  ifu_rsp_valid;
    logic [31:0]           ifu_rsp_data;

    // Data memory channel
    logic                  dmem_req_valid;
    logic                  dmem_req_ready;
    logic                  dmem_req_wen;
    logic [ADDR_WIDTH-1:0] dmem_req_addr;
    logic [XLEN-1:0]       dmem_req_wdata;
    logic [7:0]            dmem_req_wmask;
    logic                  dmem_rsp_valid;
    logic [XLEN-1:0]       dmem_rsp_rdata;

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        output dmem_req_valid, dmem_req_wen, dmem_req_addr,
        output dmem_req_wdata, dmem_req_wmask,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        input  dmem_req_valid, dmem_req_wen, dmem_req_addr,
        input  dmem_req_wdata, dmem_req_wmask,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );
endinterface

// File: rtl/ysyx_23060201_mc_ctrl.sv
// Multi-cycle core sequencer: owns PC, the instruction register and the
// fetch/execute/memory/writeback phase FSM. The combinational IDU/EXU sees the
// latched instruction; its results are captured in the single EXEC cycle and
// replayed to memory and the register file. Every output is a flop or a flop
// field, so there is no path from memory inputs to request outputs.
module ysyx_23060201_mc_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    XLEN       = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,           // asynchronous, active-low

    ysyx_23060201_mc_ctrl_if.master mem,

    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] pc,

    output logic                  exu_valid,
    input  logic                  exu_is_load,
    input  logic                  exu_is_store,
    input  logic                  exu_halt,
    input  logic                  exu_jump_en,
    input  logic [ADDR_WIDTH-1:0] exu_dnpc,
    input  logic                  exu_gpr_wen,
    input  logic [4:0]            exu_gpr_waddr,
    input  logic [XLEN-1:0]       exu_gpr_wdata,
    input  logic [ADDR_WIDTH-1:0] exu_mem_addr,
    input  logic [XLEN-1:0]       exu_mem_wdata,
    input  logic [7:0]            exu_mem_wmask,

    output logic                  gpr_wen,
    output logic [4:0]            gpr_waddr,
    output logic [XLEN-1:0]       gpr_wdata,
    output logic                  commit_valid,
    output logic [ADDR_WIDTH-1:0] commit_pc,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  instret
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FWAIT,
        S_EXEC,
        S_MEM,
        S_MWAIT,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_e                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] pc_q,      pc_d;
    logic [31:0]           inst_q,    inst_d;
    logic [CNT_WIDTH-1:0]  instret_q, instret_d;

    // Execute results captured in EXEC and held until writeback
    logic                  jump_q,    jump_d;
    logic [ADDR_WIDTH-1:0] dnpc_q,    dnpc_d;
    logic                  wen_q,     wen_d;
    logic [4:0]            waddr_q,   waddr_d;
    logic [XLEN-1:0]       wdata_q,   wdata_d;
    logic                  halt_q,    halt_d;
    logic                  is_load_q, is_load_d;
    logic                  is_store_q, is_store_d;
    logic [ADDR_WIDTH-1:0] maddr_q,   maddr_d;
    logic [XLEN-1:0]       mwdata_q,  mwdata_d;
    logic [7:0]            wmask_q,   wmask_d;

    // Registered strobes, each decoded from the next state
    logic ifu_req_valid_q,  ifu_req_valid_d;
    logic dmem_req_valid_q, dmem_req_valid_d;
    logic exu_valid_q,      exu_valid_d;
    logic gpr_wen_q,        gpr_wen_d;
    logic commit_valid_q,   commit_valid_d;
    logic halted_q,         halted_d;

    // Next-state and datapath update for the phase FSM
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        instret_d  = instret_q;
        jump_d     = jump_q;
        dnpc_d     = dnpc_q;
        wen_d      = wen_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        halt_d     = halt_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        wmask_d    = wmask_q;

        case (state_q)
            S_FETCH: begin
                // The registered valid gates the handshake, so the first
                // cycle out of reset never issues a request.
                if (ifu_req_valid_q && mem.ifu_req_ready) begin
                    state_d = S_FWAIT;
                end
            end
            S_FWAIT: begin
                if (mem.ifu_rsp_valid) begin
                    inst_d  = mem.ifu_rsp_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                jump_d     = exu_jump_en;
                dnpc_d     = exu_dnpc;
                wen_d      = exu_gpr_wen;
                waddr_d    = exu_gpr_waddr;
                wdata_d    = exu_gpr_wdata;
                halt_d     = exu_halt;
                // A simultaneous load+store is illegal and resolved as a store.
                is_store_d = exu_is_store;
                is_load_d  = exu_is_load & ~exu_is_store;
                maddr_d    = exu_mem_addr;
                mwdata_d   = exu_mem_wdata;
                wmask_d    = exu_is_store ? exu_mem_wmask : 8'h00;
                state_d    = (exu_is_load || exu_is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_req_valid_q && mem.dmem_req_ready) begin
                    state_d = S_MWAIT;
                end
            end
            S_MWAIT: begin
                // Stores also wait here: the response is the write acknowledge.
                if (mem.dmem_rsp_valid) begin
                    if (is_load_q) begin
                        wdata_d = mem.dmem_rsp_rdata;
                    end
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d      = jump_q ? dnpc_q : pc_q + ADDR_WIDTH'(4);
                instret_d = instret_q + CNT_WIDTH'(1);
                state_d   = halt_q ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        ifu_req_valid_d  = (state_d == S_FETCH);
        exu_valid_d      = (state_d == S_EXEC);
        dmem_req_valid_d = (state_d == S_MEM);
        commit_valid_d   = (state_d == S_WB);
        gpr_wen_d        = (state_d == S_WB) && wen_d && (waddr_d != 5'd0);
        halted_d         = (state_d == S_HALT);
    end

    // State, datapath latches and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_FETCH;
            pc_q             <= RESET_PC;
            inst_q           <= NOP_INST;
            instret_q        <= '0;
            jump_q           <= 1'b0;
            dnpc_q           <= '0;
            wen_q            <= 1'b0;
            waddr_q          <= '0;
            wdata_q          <= '0;
            halt_q           <= 1'b0;
            is_load_q        <= 1'b0;
            is_store_q       <= 1'b0;
            maddr_q          <= '0;
            mwdata_q         <= '0;
            wmask_q          <= '0;
            ifu_req_valid_q  <= 1'b0;
            dmem_req_valid_q <= 1'b0;
            exu_valid_q      <= 1'b0;
            gpr_wen_q        <= 1'b0;
            commit_valid_q   <= 1'b0;
            halted_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q          <= state_d;
            pc_q             <= pc_d;
            inst_q           <= inst_d;
            instret_q        <= instret_d;
            jump_q           <= jump_d;
            dnpc_q           <= dnpc_d;
            wen_q            <= wen_d;
            waddr_q          <= waddr_d;
            wdata_q          <= wdata_d;
            halt_q           <= halt_d;
            is_load_q        <= is_load_d;
            is_store_q       <= is_store_d;
            maddr_q          <= maddr_d;
            mwdata_q         <= mwdata_d;
            wmask_q          <= wmask_d;
            ifu_req_valid_q  <= ifu_req_valid_d;
            dmem_req_valid_q <= dmem_req_valid_d;
            exu_valid_q      <= exu_valid_d;
            gpr_wen_q        <= gpr_wen_d;
            commit_valid_q   <= commit_valid_d;
            halted_q         <= halted_d;
        end
    end

    assign mem.ifu_req_valid  = ifu_req_valid_q;
    assign mem.ifu_req_addr   = pc_q;
    assign mem.dmem_req_valid = dmem_req_valid_q;
    assign mem.dmem_req_wen   = is_store_q;
    assign mem.dmem_req_addr  = maddr_q;
    assign mem.dmem_req_wdata = mwdata_q;
    assign mem.dmem_req_wmask = wmask_q;

    assign inst         = inst_q;
    assign pc           = pc_q;
    assign exu_valid    = exu_valid_q;
    assign gpr_wen      = gpr_wen_q;
    assign gpr_waddr    = waddr_q;
    assign gpr_wdata    = wdata_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = pc_q;
    assign halted       = halted_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_ysyx_23060201_mc_ctrl.sv
// Bench for the multi-cycle sequencer. The bench plays both memories and the
// EXU. Each instruction is a transaction record; a small architectural model
// (PC, retired count, expected register write) predicts what must come out.
module tb_ysyx_23060201_mc_ctrl;

    localparam int          AW       = 32;
    localparam int          XL       = 32;
    localparam int          CW       = 64;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] word;
        bit          is_load;
        bit          is_store;
        bit          jump;
        bit          wen;
        bit          halt;
        logic [31:0] dnpc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [7:0]  wmask;
        logic [31:0] rdata;
        int          if_rdy_dly;
        int          if_rsp_dly;
        int          dm_rdy_dly;
        int          dm_rsp_dly;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ysyx_23060201_mc_ctrl_if #(.ADDR_WIDTH(AW), .XLEN(XL)) mem_if ();

    logic [31:0]   inst;
    logic [AW-1:0] pc;
    logic          exu_valid;
    logic          exu_is_load, exu_is_store, exu_halt, exu_jump_en;
    logic [AW-1:0] exu_dnpc;
    logic          exu_gpr_wen;
    logic [4:0]    exu_gpr_waddr;
    logic [XL-1:0] exu_gpr_wdata;
    logic [AW-1:0] exu_mem_addr;
    logic [XL-1:0] exu_mem_wdata;
    logic [7:0]    exu_mem_wmask;
    logic          gpr_wen;
    logic [4:0]    gpr_waddr;
    logic [XL-1:0] gpr_wdata;
    logic          commit_valid;
    logic [AW-1:0] commit_pc;
    logic          halted;
    logic [CW-1:0] instret;

    int vectors    = 0;
    int miscompares = 0;

    // Architectural model state
    logic [31:0] m_pc;
    logic [63:0] m_instret;

    ysyx_23060201_mc_ctrl #(
        .ADDR_WIDTH(AW), .XLEN(XL), .RESET_PC(RESET_PC), .CNT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem           (mem_if),
        .inst          (inst),
        .pc            (pc),
        .exu_valid     (exu_valid),
        .exu_is_load   (exu_is_load),
        .exu_is_store  (exu_is_store),
        .exu_halt      (exu_halt),
        .exu_jump_en   (exu_jump_en),
        .exu_dnpc      (exu_dnpc),
        .exu_gpr_wen   (exu_gpr_wen),
        .exu_gpr_waddr (exu_gpr_waddr),
        .exu_gpr_wdata (exu_gpr_wdata),
        .exu_mem_addr  (exu_mem_addr),
        .exu_mem_wdata (exu_mem_wdata),
        .exu_mem_wmask (exu_mem_wmask),
        .gpr_wen       (gpr_wen),
        .gpr_waddr     (gpr_waddr),
        .gpr_wdata     (gpr_wdata),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .halted        (halted),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk_exu();
        exu_is_load   = 1'($urandom);
        exu_is_store  = 1'($urandom);
        exu_halt      = 1'($urandom);
        exu_jump_en   = 1'($urandom);
        exu_dnpc      = $urandom;
        exu_gpr_wen   = 1'($urandom);
        exu_gpr_waddr = 5'($urandom);
        exu_gpr_wdata = $urandom;
        exu_mem_addr  = $urandom;
        exu_mem_wdata = $urandom;
        exu_mem_wmask = 8'($urandom);
    endtask

    task automatic drive_exu(input op_t op);
        exu_is_load   = op.is_load;
        exu_is_store  = op.is_store;
        exu_halt      = op.halt;
        exu_jump_en   = op.jump;
        exu_dnpc      = op.dnpc;
        exu_gpr_wen   = op.wen;
        exu_gpr_waddr = op.waddr;
        exu_gpr_wdata = op.wdata;
        exu_mem_addr  = op.maddr;
        exu_mem_wdata = op.mwdata;
        exu_mem_wmask = op.wmask;
    endtask

    task automatic check_dmem_req(input op_t op);
        check("dmem_req_valid", mem_if.dmem_req_valid, 1'b1);
        check("dmem_req_wen",   mem_if.dmem_req_wen, op.is_store);
        check("dmem_req_addr",  mem_if.dmem_req_addr, op.maddr);
        check("dmem_req_wdata", mem_if.dmem_req_wdata, op.mwdata);
        check("dmem_req_wmask", mem_if.dmem_req_wmask, op.is_store ? op.wmask : 8'h00);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ifu_valid"},  mem_if.ifu_req_valid, 1'b0);
        check({tag, "_dmem_valid"}, mem_if.dmem_req_valid, 1'b0);
        check({tag, "_exu_valid"},  exu_valid, 1'b0);
        check({tag, "_gpr_wen"},    gpr_wen, 1'b0);
        check({tag, "_commit"},     commit_valid, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        mem_if.ifu_req_ready  = 1'b0;
        mem_if.ifu_rsp_valid  = 1'b0;
        mem_if.ifu_rsp_data   = '0;
        mem_if.dmem_req_ready = 1'b0;
        mem_if.dmem_rsp_valid = 1'b0;
        mem_if.dmem_rsp_rdata = '0;
        drive_junk_exu();
        step();
        step();
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_instret", instret, 64'd0);
        check("rst_halted", halted, 1'b0);
        check_idle_outputs("rst");
        m_pc      = RESET_PC;
        m_instret = 64'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Random legal-ish instruction record; illegal load+store appears rarely.
    function automatic op_t rand_op();
        op_t op;
        int  kind;
        kind        = $urandom_range(0, 9);
        op.word     = $urandom;
        op.is_load  = (kind == 1 || kind == 2 || kind == 9);
        op.is_store = (kind == 3 || kind == 4 || kind == 9);
        op.jump     = ($urandom_range(0, 3) == 0);
        op.wen      = 1'($urandom);
        op.halt     = 1'b0;
        op.dnpc     = RESET_PC + {20'd0, 10'($urandom), 2'b00};
        op.waddr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        op.wdata    = $urandom;
        op.maddr    = $urandom;
        op.mwdata   = $urandom;
        op.wmask    = 8'($urandom);
        op.rdata    = $urandom;
        op.if_rdy_dly = $urandom_range(0, 3);
        op.if_rsp_dly = $urandom_range(1, 3);
        op.dm_rdy_dly = $urandom_range(0, 3);
        op.dm_rsp_dly = $urandom_range(1, 3);
        return op;
    endfunction

    function automatic op_t alu_op(input logic [31:0] word, input logic [4:0] rd, input logic [31:0] val);
        op_t op;
        op = rand_op();
        op.word = word; op.is_load = 0; op.is_store = 0; op.jump = 0; op.halt = 0;
        op.wen = 1; op.waddr = rd; op.wdata = val;
        op.if_rdy_dly = 0; op.if_rsp_dly = 1;
        return op;
    endfunction

    // One full instruction; abort_mwait pulls reset asynchronously in MWAIT.
    task automatic run_op(input op_t op, input bit abort_mwait);
        int          n;
        bit          exp_wen;
        bit          eff_load;
        logic [31:0] exp_data;

        eff_load = op.is_load && !op.is_store;
        exp_wen  = op.wen && (op.waddr != 5'd0);
        exp_data = eff_load ? op.rdata : op.wdata;

        n = 0;
        while (mem_if.ifu_req_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("fetch_valid", mem_if.ifu_req_valid, 1'b1);
        check("fetch_addr", mem_if.ifu_req_addr, m_pc);

        // Stall on ready; stray responses here must be ignored.
        for (int i = 0; i < op.if_rdy_dly; i++) begin
            mem_if.ifu_rsp_valid = 1'($urandom);
            mem_if.ifu_rsp_data  = $urandom;
            step();
            check("fetch_hold_valid", mem_if.ifu_req_valid, 1'b1);
            check("fetch_hold_addr", mem_if.ifu_req_addr, m_pc);
        end
        mem_if.ifu_req_ready = 1'b1;
        mem_if.ifu_rsp_valid = 1'($urandom);
        mem_if.ifu_rsp_data  = $urandom;
        step();
        mem_if.ifu_req_ready = 1'b0;
        mem_if.ifu_rsp_valid = 1'b0;
        check("fetch_drop", mem_if.ifu_req_valid, 1'b0);

        for (int i = 1; i < op.if_rsp_dly; i++) begin
            step();
            check("fwait_no_exec", exu_valid, 1'b0);
        end
        mem_if.ifu_rsp_valid = 1'b1;
        mem_if.ifu_rsp_data  = op.word;
        step();
        mem_if.ifu_rsp_valid = 1'b0;
        mem_if.ifu_rsp_data  = $urandom;
        check("exec_valid", exu_valid, 1'b1);
        check("inst", inst, op.word);

        drive_exu(op);
        step();
        drive_junk_exu();
        check("exec_one_cycle", exu_valid, 1'b0);

        if (op.is_load || op.is_store) begin
            check_dmem_req(op);
            for (int i = 0; i < op.dm_rdy_dly; i++) begin
                mem_if.dmem_rsp_valid = 1'($urandom);
                mem_if.dmem_rsp_rdata = $urandom;
                step();
                check_dmem_req(op);
            end
            mem_if.dmem_req_ready = 1'b1;
            mem_if.dmem_rsp_valid = 1'b0;
            step();
            mem_if.dmem_req_ready = 1'b0;
            check("dmem_drop", mem_if.dmem_req_valid, 1'b0);

            if (abort_mwait) begin
                #2;
                rst = 1'b0;
                #1;
                check("abort_pc", pc, RESET_PC);
                check("abort_instret", instret, 64'd0);
                check("abort_inst", inst, 32'h0000_0013);
                check("abort_halted", halted, 1'b0);
                check_idle_outputs("abort");
                m_pc      = RESET_PC;
                m_instret = 64'd0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end

            for (int i = 1; i < op.dm_rsp_dly; i++) begin
                step();
                check("mwait_no_commit", commit_valid, 1'b0);
            end
            mem_if.dmem_rsp_valid = 1'b1;
            mem_if.dmem_rsp_rdata = op.rdata;
            step();
            mem_if.dmem_rsp_valid = 1'b0;
            mem_if.dmem_rsp_rdata = $urandom;
        end

        check("wb_commit", commit_valid, 1'b1);
        check("wb_commit_pc", commit_pc, m_pc);
        check("wb_gpr_wen", gpr_wen, exp_wen);
        if (exp_wen) begin
            check("wb_gpr_waddr", gpr_waddr, op.waddr);
            check("wb_gpr_wdata", gpr_wdata, exp_data);
        end
        check("wb_instret", instret, m_instret);

        m_pc      = op.jump ? op.dnpc : m_pc + 32'd4;
        m_instret = m_instret + 64'd1;

        step();
        check("post_commit", commit_valid, 1'b0);
        check("post_gpr_wen", gpr_wen, 1'b0);
        check("post_instret", instret, m_instret);
        if (op.halt) begin
            check("halted", halted, 1'b1);
            mem_if.ifu_req_ready  = 1'b1;
            mem_if.dmem_req_ready = 1'b1;
            for (int i = 0; i < 6; i++) begin
                mem_if.ifu_rsp_valid  = 1'($urandom);
                mem_if.dmem_rsp_valid = 1'($urandom);
                step();
                check("halt_stay", halted, 1'b1);
                check_idle_outputs("halt");
                check("halt_instret", instret, m_instret);
            end
            mem_if.ifu_req_ready  = 1'b0;
            mem_if.dmem_req_ready = 1'b0;
            mem_if.ifu_rsp_valid  = 1'b0;
            mem_if.dmem_rsp_valid = 1'b0;
        end else begin
            check("not_halted", halted, 1'b0);
            check("next_fetch_valid", mem_if.ifu_req_valid, 1'b1);
            check("next_fetch_addr", mem_if.ifu_req_addr, m_pc);
        end
    endtask

    initial begin
        op_t op;

        // Step 1: reset state
        apply_reset();

        // Step 2: addi x1, x0, 5 with immediate ready and 1-cycle response
        op = alu_op(32'h0050_0093, 5'd1, 32'd5);
        run_op(op, 1'b0);
        check("addi_pc_next", pc, 32'h8000_0004);
        check("addi_instret", instret, 64'd1);

        // Step 3: fetch ready held low for 7 cycles
        op = alu_op($urandom, 5'd2, $urandom);
        op.if_rdy_dly = 7;
        run_op(op, 1'b0);

        // Step 4: load from 0x8000_0100, response 3 cycles after acceptance
        op = rand_op();
        op.is_load = 1; op.is_store = 0; op.jump = 0; op.wen = 1; op.waddr = 5'd7;
        op.maddr = 32'h8000_0100; op.rdata = 32'hDEAD_BEEF;
        op.dm_rdy_dly = 0; op.dm_rsp_dly = 3;
        run_op(op, 1'b0);

        // Step 5: store with wmask 0x0F, ready delayed 2 cycles
        op = rand_op();
        op.is_load = 0; op.is_store = 1; op.jump = 0; op.wen = 0;
        op.wmask = 8'h0F; op.dm_rdy_dly = 2; op.dm_rsp_dly = 1;
        run_op(op, 1'b0);

        // Step 6: jump to 0x8000_0040 with a write to x0 that must be dropped
        op = alu_op($urandom, 5'd0, $urandom);
        op.jump = 1; op.dnpc = 32'h8000_0040;
        run_op(op, 1'b0);

        // Step 7: jump to the top of the address space, then wrap on pc+4
        op = alu_op($urandom, 5'd3, $urandom);
        op.jump = 1; op.dnpc = 32'hFFFF_FFFC;
        run_op(op, 1'b0);
        op = alu_op($urandom, 5'd4, $urandom);
        run_op(op, 1'b0);
        check("pc_wrap", pc, 32'h0000_0000);

        // Step 8: illegal load+store resolves as a store
        op = rand_op();
        op.is_load = 1; op.is_store = 1; op.wen = 1; op.waddr = 5'd9; op.wmask = 8'hA5;
        run_op(op, 1'b0);

        // Step 9: randomized instruction stream
        for (int k = 0; k < 40; k++) begin
            op = rand_op();
            run_op(op, 1'b0);
        end

        // Step 10: ebreak retires once then the core freezes
        op = alu_op($urandom, 5'd5, $urandom);
        op.halt = 1;
        run_op(op, 1'b0);

        // Step 11: reset recovers; reset again in the middle of MWAIT
        apply_reset();
        op = alu_op($urandom, 5'd6, $urandom);
        run_op(op, 1'b0);
        op = rand_op();
        op.is_load = 1; op.is_store = 0;
        run_op(op, 1'b1);

        // Step 12: first instruction after the abort retires from RESET_PC
        op = alu_op($urandom, 5'd8, $urandom);
        run_op(op, 1'b0);
        check("after_abort_instret", instret, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
